// File: rtl/memory_pkg.sv
// Shared types for the LEGv8 memory stage: FSM states and EX/MEM, MEM/WB register layouts.
// Widths here set the stage datapath; the top-level parameters must match them.
package memory_pkg;

   localparam int MEM_DATA_W = 64;
   localparam int MEM_REG_W  = 5;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_BUSY = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic                  valid;
      logic                  mem_read;
      logic                  mem_write;
      logic                  branch;
      logic                  zero;
      logic                  reg_write;
      logic                  mem_to_reg;
      logic [MEM_REG_W-1:0]  write_reg;
      logic [MEM_DATA_W-1:0] alu_result;
      logic [MEM_DATA_W-1:0] write_data;
      logic [MEM_DATA_W-1:0] pc_branch;
   } ex_mem_t;

   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic [MEM_REG_W-1:0]  write_reg;
      logic [MEM_DATA_W-1:0] result;
   } mem_wb_t;

endpackage

// File: rtl/memory_access_if.sv
// Data-memory req/ack bus: the stage (master) holds req/we/addr/wdata until ack; rdata valid with ack.
// No latency of its own; the memory (slave) backpressures by withholding ack.
interface memory_access_if #(parameter int DATA_W = 64);

   logic              dm_req;
   logic              dm_we;
   logic [DATA_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_ack;
   logic [DATA_W-1:0] dm_rdata;

   modport master (
      output dm_req, dm_we, dm_addr, dm_wdata,
      input  dm_ack, dm_rdata
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_wdata,
      output dm_ack, dm_rdata
   );

endinterface

// File: rtl/pipeline_register.sv
// Generic stage register: async active-low clear, loads d_i when en_i is high.
// One clock latency; en_i low holds the current contents.
module pipeline_register #(
   parameter type T = logic
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en_i,
   input  T     d_i,
   output T     q_o
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_o <= '0;
      end else if (en_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/memory_access.sv
// LEGv8 memory stage: EX/MEM register, data-memory req/ack FSM, branch resolve, MEM/WB register.
// E->W in 2 clocks (+k for an ack k cycles late); stall_M holds upstream while an access is unacked.
module memory_access
   import memory_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W,
   parameter int REG_W  = MEM_REG_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              valid_E,
   input  logic [DATA_W-1:0] aluResult_E,
   input  logic [DATA_W-1:0] writeData_E,
   input  logic [DATA_W-1:0] PCBranch_E,
   input  logic              zero_E,
   input  logic              MemRead_E,
   input  logic              MemWrite_E,
   input  logic              Branch_E,
   input  logic              RegWrite_E,
   input  logic              MemtoReg_E,
   input  logic [REG_W-1:0]  writeReg_E,
   output logic              stall_M,
   output logic              PCSrc_M,
   output logic [DATA_W-1:0] PCBranch_M,
   output logic              valid_W,
   output logic              RegWrite_W,
   output logic [REG_W-1:0]  writeReg_W,
   output logic [DATA_W-1:0] result_W,
   memory_access_if.master   dm
);

   ex_mem_t    ex_mem_d, ex_mem_q;
   mem_wb_t    mem_wb_d, mem_wb_q;
   mem_state_t state_d, state_q;
   logic       memop_M;

   // A bubble carries no control bits, so nothing downstream can act on stale data.
   always_comb begin
      ex_mem_d            = '0;
      ex_mem_d.valid      = valid_E;
      ex_mem_d.mem_read   = valid_E & MemRead_E;
      ex_mem_d.mem_write  = valid_E & MemWrite_E;
      ex_mem_d.branch     = valid_E & Branch_E;
      ex_mem_d.zero       = valid_E & zero_E;
      ex_mem_d.reg_write  = valid_E & RegWrite_E;
      ex_mem_d.mem_to_reg = valid_E & MemtoReg_E;
      ex_mem_d.write_reg  = writeReg_E;
      ex_mem_d.alu_result = aluResult_E;
      ex_mem_d.write_data = writeData_E;
      ex_mem_d.pc_branch  = PCBranch_E;
   end

   pipeline_register #(.T(ex_mem_t)) u_ex_mem (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (~stall_M),
      .d_i     (ex_mem_d),
      .q_o     (ex_mem_q)
   );

   // The ack cycle always releases the stall, so EX/MEM advances on the same edge the
   // access completes; a new instruction never sees a previous instruction's ack.
   assign memop_M     = ex_mem_q.valid & (ex_mem_q.mem_read | ex_mem_q.mem_write);
   assign dm.dm_req   = memop_M;
   assign dm.dm_we    = ex_mem_q.mem_write;
   assign dm.dm_addr  = ex_mem_q.alu_result;
   assign dm.dm_wdata = ex_mem_q.write_data;
   assign stall_M     = memop_M & ~dm.dm_ack;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= MEM_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MEM_IDLE: if (memop_M && !dm.dm_ack) state_d = MEM_BUSY;
         MEM_BUSY: if (dm.dm_ack)             state_d = MEM_IDLE;
         default:                             state_d = MEM_IDLE;
      endcase
   end

   assign PCSrc_M    = ex_mem_q.valid & ex_mem_q.branch & ex_mem_q.zero;
   assign PCBranch_M = ex_mem_q.pc_branch;

   always_comb begin
      mem_wb_d           = '0;
      mem_wb_d.valid     = ex_mem_q.valid & ~stall_M;
      mem_wb_d.reg_write = ex_mem_q.reg_write & ex_mem_q.valid & ~stall_M;
      mem_wb_d.write_reg = ex_mem_q.write_reg;
      mem_wb_d.result    = ex_mem_q.mem_to_reg ? dm.dm_rdata : ex_mem_q.alu_result;
   end

   pipeline_register #(.T(mem_wb_t)) u_mem_wb (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (1'b1),
      .d_i     (mem_wb_d),
      .q_o     (mem_wb_q)
   );

   assign valid_W    = mem_wb_q.valid;
   assign RegWrite_W = mem_wb_q.reg_write;
   assign writeReg_W = mem_wb_q.write_reg;
   assign result_W   = mem_wb_q.result;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed instructions, scoreboard of expected writebacks, simple ack-delay memory.
module tb_memory_access;
   import memory_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        valid_E, zero_E, MemRead_E, MemWrite_E, Branch_E, RegWrite_E, MemtoReg_E;
   logic [63:0] aluResult_E, writeData_E, PCBranch_E;
   logic [4:0]  writeReg_E;
   logic        stall_M, PCSrc_M, valid_W, RegWrite_W;
   logic [63:0] PCBranch_M, result_W;
   logic [4:0]  writeReg_W;

   memory_access_if #(.DATA_W(64)) dm_bus ();

   memory_access dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .valid_E     (valid_E),
      .aluResult_E (aluResult_E),
      .writeData_E (writeData_E),
      .PCBranch_E  (PCBranch_E),
      .zero_E      (zero_E),
      .MemRead_E   (MemRead_E),
      .MemWrite_E  (MemWrite_E),
      .Branch_E    (Branch_E),
      .RegWrite_E  (RegWrite_E),
      .MemtoReg_E  (MemtoReg_E),
      .writeReg_E  (writeReg_E),
      .stall_M     (stall_M),
      .PCSrc_M     (PCSrc_M),
      .PCBranch_M  (PCBranch_M),
      .valid_W     (valid_W),
      .RegWrite_W  (RegWrite_W),
      .writeReg_W  (writeReg_W),
      .result_W    (result_W),
      .dm          (dm_bus.master)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: acks once req has been up for ack_delay cycles, or at once when ack_force.
   int          req_cnt;
   int          ack_delay = 0;
   logic        ack_force = 1'b0;
   logic [63:0] rdata_v   = 64'd0;
   assign dm_bus.dm_ack   = ack_force | (dm_bus.dm_req & (req_cnt >= ack_delay));
   assign dm_bus.dm_rdata = rdata_v;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)                            req_cnt <= 0;
      else if (dm_bus.dm_req & ~dm_bus.dm_ack) req_cnt <= req_cnt + 1;
      else                                     req_cnt <= 0;
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          cyc;
      logic        rw;
      logic [4:0]  wr;
      logic [63:0] res;
   } exp_t;
   exp_t sb[$];

   task automatic expect_w(input int lat, input logic rw, input logic [4:0] wr, input logic [63:0] res);
      exp_t e;
      e.cyc = cyc + lat;
      e.rw  = rw;
      e.wr  = wr;
      e.res = res;
      sb.push_back(e);
   endtask

   // Monitor: every writeback pulse must match the oldest expectation, including its cycle.
   always @(negedge clk) begin
      if (valid_W === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid_W", 64'(valid_W), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_cycle", 64'(cyc), 64'(e.cyc));
            chk("wb_regwrite", 64'(RegWrite_W), 64'(e.rw));
            chk("wb_writereg", 64'(writeReg_W), 64'(e.wr));
            chk("wb_result", result_W, e.res);
         end
      end else begin
         chk("regwrite_without_valid", 64'(RegWrite_W), 64'd0);
      end
   end

   task automatic issue(input logic rd, input logic wr, input logic br, input logic z,
                        input logic rw, input logic m2r, input logic [63:0] alu,
                        input logic [63:0] wd, input logic [63:0] pcb, input logic [4:0] wreg);
      valid_E     = 1'b1;
      MemRead_E   = rd;
      MemWrite_E  = wr;
      Branch_E    = br;
      zero_E      = z;
      RegWrite_E  = rw;
      MemtoReg_E  = m2r;
      aluResult_E = alu;
      writeData_E = wd;
      PCBranch_E  = pcb;
      writeReg_E  = wreg;
   endtask

   task automatic bubble();
      issue(0, 0, 0, 0, 0, 0, 64'd0, 64'd0, 64'd0, 5'd0);
      valid_E = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      bubble();
      repeat (2) @(negedge clk);
      chk("rst_stall", 64'(stall_M), 64'd0);
      chk("rst_pcsrc", 64'(PCSrc_M), 64'd0);
      chk("rst_req", 64'(dm_bus.dm_req), 64'd0);
      chk("rst_we", 64'(dm_bus.dm_we), 64'd0);
      chk("rst_valid_W", 64'(valid_W), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // 1: ALU op, two clocks to writeback, never stalls
      issue(0, 0, 0, 0, 1, 0, 64'd55, 64'd0, 64'd0, 5'd3);
      expect_w(2, 1'b1, 5'd3, 64'd55);
      @(negedge clk);
      chk("alu_stall", 64'(stall_M), 64'd0);
      chk("alu_req", 64'(dm_bus.dm_req), 64'd0);
      bubble();
      @(negedge clk);
      chk("alu_stall2", 64'(stall_M), 64'd0);

      // 2: zero-wait load with ack tied high
      ack_force = 1'b1;
      rdata_v   = 64'hABCD;
      issue(1, 0, 0, 0, 1, 1, 64'd46, 64'd0, 64'd0, 5'd4);
      expect_w(2, 1'b1, 5'd4, 64'hABCD);
      @(negedge clk);
      chk("ld0_req", 64'(dm_bus.dm_req), 64'd1);
      chk("ld0_we", 64'(dm_bus.dm_we), 64'd0);
      chk("ld0_addr", dm_bus.dm_addr, 64'd46);
      chk("ld0_stall", 64'(stall_M), 64'd0);
      // Read and write both set behaves as a write
      issue(1, 1, 0, 0, 0, 0, 64'd12, 64'd77, 64'd0, 5'd5);
      expect_w(2, 1'b0, 5'd5, 64'd12);
      @(negedge clk);
      chk("rw_we", 64'(dm_bus.dm_we), 64'd1);
      chk("rw_wdata", dm_bus.dm_wdata, 64'd77);
      bubble();
      @(negedge clk);
      chk("ld0_req_drop", 64'(dm_bus.dm_req), 64'd0);
      ack_force = 1'b0;

      // 3: store acked three cycles late
      ack_delay = 3;
      issue(0, 1, 0, 0, 0, 0, 64'd8, 64'd32, 64'd0, 5'd7);
      expect_w(5, 1'b0, 5'd7, 64'd8);
      @(negedge clk);
      bubble();
      for (int i = 0; i < 4; i++) begin
         chk("st_req", 64'(dm_bus.dm_req), 64'd1);
         chk("st_we", 64'(dm_bus.dm_we), 64'd1);
         chk("st_addr", dm_bus.dm_addr, 64'd8);
         chk("st_wdata", dm_bus.dm_wdata, 64'd32);
         chk("st_stall", 64'(stall_M), (i < 3) ? 64'd1 : 64'd0);
         @(negedge clk);
      end
      chk("st_req_drop", 64'(dm_bus.dm_req), 64'd0);
      ack_delay = 0;

      // 4: taken branch then not-taken branch back to back
      issue(0, 0, 1, 1, 0, 0, 64'd0, 64'd0, 64'd23, 5'd0);
      expect_w(2, 1'b0, 5'd0, 64'd0);
      @(negedge clk);
      chk("br_taken", 64'(PCSrc_M), 64'd1);
      chk("br_target", PCBranch_M, 64'd23);
      chk("br_nostall", 64'(stall_M), 64'd0);
      issue(0, 0, 1, 0, 0, 0, 64'd5, 64'd0, 64'd99, 5'd0);
      expect_w(2, 1'b0, 5'd0, 64'd5);
      @(negedge clk);
      chk("br_not_taken", 64'(PCSrc_M), 64'd0);
      chk("br_target2", PCBranch_M, 64'd99);
      bubble();
      @(negedge clk);
      chk("br_idle", 64'(PCSrc_M), 64'd0);

      // 5: reset during the second cycle of a delayed load
      ack_delay = 5;
      issue(1, 0, 0, 0, 1, 1, 64'd100, 64'd0, 64'd0, 5'd9);
      @(negedge clk);
      bubble();
      chk("rl_req", 64'(dm_bus.dm_req), 64'd1);
      chk("rl_stall", 64'(stall_M), 64'd1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rl_req_cleared", 64'(dm_bus.dm_req), 64'd0);
      chk("rl_stall_cleared", 64'(stall_M), 64'd0);
      chk("rl_valid_W", 64'(valid_W), 64'd0);
      chk("rl_regwrite_W", 64'(RegWrite_W), 64'd0);
      @(negedge clk);
      reset_n   = 1'b1;
      ack_delay = 0;
      @(negedge clk);
      chk("rl_fsm_idle", 64'(dut.state_q), 64'(MEM_IDLE));
      chk("rl_stall_after", 64'(stall_M), 64'd0);
      issue(0, 0, 0, 0, 1, 0, 64'd1234, 64'd0, 64'd0, 5'd11);
      expect_w(2, 1'b1, 5'd11, 64'd1234);
      @(negedge clk);
      bubble();
      repeat (4) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
